// File: rtl/serial_full_adder.sv
// ============================================================================
// Module   : serial_full_adder
// Brief    : Bit-serial adder, LSB-first, one full-adder bit per clock through
//            a single carry flop. The optional signed-overflow output is
//            enabled by defining SIGNED_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_c;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_SHIFT) && (r_count == c_last);
    assign w_s      = r_sa[0] ^ r_sb[0] ^ r_carry;
    assign w_c      = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

`ifdef SIGNED_OVF_EN
    logic r_cmsb;

    // Carry into the MSB is the carry flop value while the last bit is processed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmsb <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (w_last) r_cmsb <= r_carry;
            if (r_state == S_DONE) ovf <= r_cmsb ^ r_carry;
        end
    end
`endif

    // Handshake and result outputs lag the FSM by one cycle, so sum/cout/done
    // appear together and never expose partial results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
        end else begin
            busy <= (r_state == S_SHIFT);
            done <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                sum  <= r_res;
                cout <= r_carry;
            end
            if (w_accept) begin
                r_sa    <= a;
                r_sb    <= b;
                r_carry <= cin;
                r_res   <= '0;
                r_count <= '0;
            end else if (r_state == S_SHIFT) begin
                r_sa    <= r_sa >> 1;
                r_sb    <= r_sb >> 1;
                r_res   <= {w_s, r_res[WIDTH-1:1]};
                r_carry <= w_c;
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_full_adder.sv
// ============================================================================
// Module   : tb_serial_full_adder
// Brief    : Directed self-checking bench for serial_full_adder (WIDTH=8);
//            checks ovf when SIGNED_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_full_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SIGNED_OVF_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_full_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation; glitch>0 pulses start (with junk operands) that many cycles after acceptance.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic [7:0] es, input logic ec,
                          input logic eovf, input int glitch);
        int cyc;
        int bcyc;
        int extra;
        bit seen;
        a = ta; b = tb; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; bcyc = 0; seen = 1'b0; extra = 0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (busy) bcyc++;
            if (done) seen = 1'b1;
            if (glitch != 0 && cyc == glitch) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end else if (glitch != 0 && cyc == glitch + 1) begin
                start = 1'b0;
            end
        end
        check_eq({tag, " done_seen"}, 32'(seen), 32'd1);
        check_eq({tag, " latency"}, 32'(cyc), 32'd9);
        check_eq({tag, " busy_cycles"}, 32'(bcyc), 32'd8);
        check_eq({tag, " sum"}, 32'(sum), 32'(es));
        check_eq({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef SIGNED_OVF_EN
        check_eq({tag, " ovf"}, 32'(ovf), 32'(eovf));
`endif
        tick();
        check_eq({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check_eq({tag, " sum_held"}, 32'(sum), 32'(es));
        repeat (3) begin
            tick();
            if (done || busy) extra++;
        end
        check_eq({tag, " quiet_after"}, 32'(extra), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int dcnt;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) tick();
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset sum", 32'(sum), 32'd0);
        check_eq("reset cout", 32'(cout), 32'd0);
`ifdef SIGNED_OVF_EN
        check_eq("reset ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        tick();

        run_op("t1_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
        run_op("t2_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op("t2_cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);
        run_op("t3_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        run_op("t3_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 0);
        run_op("t4_ignore", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3);

        // Back-to-back: second start presented while the FSM sits in DONE.
        a = 8'h5A; b = 8'hA5; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        tick();
        check_eq("t6 first_done", 32'(done), 32'd1);
        check_eq("t6 first_sum", 32'(sum), 32'hFF);
        check_eq("t6 first_cout", 32'(cout), 32'd0);
        start = 1'b0;
        cyc = 0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (done) break;
        end
        check_eq("t6 gap", 32'(cyc), 32'd9);
        check_eq("t6 sum", 32'(sum), 32'h00);
        check_eq("t6 cout", 32'(cout), 32'd1);
`ifdef SIGNED_OVF_EN
        check_eq("t6 ovf", 32'(ovf), 32'd0);
`endif
        repeat (3) tick();

        // Reset in the middle of an operation.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check_eq("t5 busy", 32'(busy), 32'd0);
        check_eq("t5 done", 32'(done), 32'd0);
        check_eq("t5 sum", 32'(sum), 32'd0);
        check_eq("t5 cout", 32'(cout), 32'd0);
        tick();
        rst = 1'b0;
        dcnt = 0;
        repeat (15) begin
            tick();
            if (done || busy) dcnt++;
        end
        check_eq("t5 no_done", 32'(dcnt), 32'd0);
        run_op("t5_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
